pip_hazard_ctrl: RTL and testbench

PIP_HAZARD_CTRL -- requirements
Module: pip_hazard_ctrl

---
 rtl/pip_pkg.sv | 39 +++
 rtl/pip_fwd_unit.sv | 26 ++
 rtl/pip_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pip_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pip_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Holds the rdmuxSel LOAD code, forwarding select codes, FSM states,
// shadow-stage record layouts and the register-write hit helper.
package pip_pkg;

  // Write-back select value that marks a load in EX.
  localparam logic [1:0] LOAD      = 2'b01;

  // ALU operand source selects.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

  // Shadow copy of the EX/MEM register fields relevant to hazards.
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } exmem_t;

  // Shadow copy of the MEM/WB register fields relevant to hazards.
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } memwb_t;

  // A downstream writer supplies rs when it really writes a non-x0 register.
  function automatic logic wr_hit(input logic [4:0] rd, input logic we,
                                  input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pip_fwd_unit.sv
// Forwarding select for one ALU operand: EX/MEM result wins over MEM/WB.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows the shadow registers held by the parent.
// Ports: rs_ad_i operand address in EX; exmem_*/memwb_* shadow writer info;
//        fwd_sel_o operand source select (FWD_REG/FWD_EXMEM/FWD_MEMWB).
module pip_fwd_unit
  import pip_pkg::*;
(
  input  logic [4:0] rs_ad_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       exmem_we_i,
  input  logic [4:0] memwb_rd_i,
  input  logic       memwb_we_i,
  output logic [1:0] fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_REG;
    if (wr_hit(exmem_rd_i, exmem_we_i, rs_ad_i)) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (wr_hit(memwb_rd_i, memwb_we_i, rs_ad_i)) begin
      fwd_sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch
// flush and data-memory wait hold, plus a saturating stall/flush counter.
// Latency: all control outputs are combinational from the current inputs;
// only the shadow stages, FSM state and stall_cnt are registered.
// Backpressure: dm_busy freezes the whole pipe (all enables low, shadow held).
// Ports: clk/rst_n; ID sources (rs*_ad_d, rs*_used_d); ID/EX fields
//        (rs*_ad_p, rd_ad_p, rdEn_p, rdmuxSel_p); branch_taken_ex; dm_busy;
//        stage enables/flush/bubble; fwdA_sel/fwdB_sel; stall_cnt.
module pip_hazard_ctrl
  import pip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_ad_d,
  input  logic [4:0]  rs2_ad_d,
  input  logic        rs1_used_d,
  input  logic        rs2_used_d,
  input  logic [4:0]  rs1_ad_p,
  input  logic [4:0]  rs2_ad_p,
  input  logic [4:0]  rd_ad_p,
  input  logic        rdEn_p,
  input  logic [1:0]  rdmuxSel_p,
  input  logic        branch_taken_ex,
  input  logic        dm_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_bubble,
  output logic [1:0]  fwdA_sel,
  output logic [1:0]  fwdB_sel,
  output logic [15:0] stall_cnt
);

  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;
  hz_state_e   state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;
  logic        stall_evt;

  // The EX/MEM load flag is tracked with the rest of the stage so the shadow
  // mirrors the real register; nothing in this block consumes it yet.
  logic        unused_exmem_ld;
  assign unused_exmem_ld = exmem_q.ld;

  // ---------------------------------------------------------------------------
  // Downstream shadow: advances with the pipe, frozen while memory is busy.
  // ---------------------------------------------------------------------------
  always_comb begin
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (!dm_busy) begin
      exmem_d.rd = rd_ad_p;
      exmem_d.we = rdEn_p;
      exmem_d.ld = (rdmuxSel_p == LOAD);
      memwb_d.rd = exmem_q.rd;
      memwb_d.we = exmem_q.we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding, one compare unit per ALU operand.
  // ---------------------------------------------------------------------------
  pip_fwd_unit u_fwd_a (
    .rs_ad_i    (rs1_ad_p),
    .exmem_rd_i (exmem_q.rd),
    .exmem_we_i (exmem_q.we),
    .memwb_rd_i (memwb_q.rd),
    .memwb_we_i (memwb_q.we),
    .fwd_sel_o  (fwdA_sel)
  );

  pip_fwd_unit u_fwd_b (
    .rs_ad_i    (rs2_ad_p),
    .exmem_rd_i (exmem_q.rd),
    .exmem_we_i (exmem_q.we),
    .memwb_rd_i (memwb_q.rd),
    .memwb_we_i (memwb_q.we),
    .fwd_sel_o  (fwdB_sel)
  );

  // ---------------------------------------------------------------------------
  // Load-use: the ID instruction needs a value still being loaded in EX.
  // Masked in REDIRECT because ID then holds a flushed NOP.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use = rdEn_p && (rdmuxSel_p == LOAD) && (rd_ad_p != 5'd0) &&
               ((rs1_used_d && (rs1_ad_d == rd_ad_p)) ||
                (rs2_used_d && (rs2_ad_d == rd_ad_p))) &&
               (state_q != REDIRECT);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A branch held in EX across a memory wait is taken on the first free cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dm_busy)              state_d = MEM_WAIT;
        else if (branch_taken_ex) state_d = REDIRECT;
      end
      MEM_WAIT: begin
        if (!dm_busy) state_d = branch_taken_ex ? REDIRECT : RUN;
      end
      REDIRECT: begin
        if (dm_busy)              state_d = MEM_WAIT;
        else if (branch_taken_ex) state_d = REDIRECT;
        else                      state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs react to the live inputs so stalls and flushes cost no extra cycle;
  // reset forces the free-running values regardless of what inputs show.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b1;
    end else if (dm_busy) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
    end else if (branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall/flush cycle counter, saturating.
  // ---------------------------------------------------------------------------
  assign stall_evt = !pc_en || if_id_flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Self-checking bench for pip_hazard_ctrl.
// Each row drives one pipeline cycle; its expected outputs are queued on drive
// and popped when the outputs are sampled on the falling edge.
module tb_pip_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_ad_d, rs2_ad_d, rs1_ad_p, rs2_ad_p, rd_ad_p;
  logic        rs1_used_d, rs2_used_d, rdEn_p, branch_taken_ex, dm_busy;
  logic [1:0]  rdmuxSel_p;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic [1:0]  fwdA_sel, fwdB_sel;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pip_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ad_d(rs1_ad_d), .rs2_ad_d(rs2_ad_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rs1_ad_p(rs1_ad_p), .rs2_ad_p(rs2_ad_p), .rd_ad_p(rd_ad_p),
    .rdEn_p(rdEn_p), .rdmuxSel_p(rdmuxSel_p),
    .branch_taken_ex(branch_taken_ex), .dm_busy(dm_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .stall_cnt(stall_cnt)
  );

  // ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble}
  localparam logic [4:0] C_RUN  = 5'b11010;
  localparam logic [4:0] C_LU   = 5'b00011;
  localparam logic [4:0] C_BR   = 5'b11111;
  localparam logic [4:0] C_HOLD = 5'b00000;
  localparam logic [1:0] F_R = 2'b00, F_E = 2'b10, F_M = 2'b01;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d;
    logic       u1, u2;
    logic [4:0] rs1_p, rs2_p, rd_p;
    logic       en;
    logic [1:0] mux;
    logic       br, busy;
  } stim_t;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    stim_t      s;
    logic [4:0] ctl;
    logic [1:0] fa, fb;
  } row_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic row_t R(input logic [4:0] rs1_d, input logic [4:0] rs2_d,
                             input logic u1, input logic u2,
                             input logic [4:0] rs1_p, input logic [4:0] rs2_p,
                             input logic [4:0] rd_p, input logic en,
                             input logic [1:0] mux, input logic br, input logic busy,
                             input logic [4:0] ctl, input logic [1:0] fa,
                             input logic [1:0] fb);
    row_t r;
    r.s.rs1_d = rs1_d; r.s.rs2_d = rs2_d; r.s.u1 = u1; r.s.u2 = u2;
    r.s.rs1_p = rs1_p; r.s.rs2_p = rs2_p; r.s.rd_p = rd_p; r.s.en = en;
    r.s.mux = mux; r.s.br = br; r.s.busy = busy;
    r.ctl = ctl; r.fa = fa; r.fb = fb;
    return r;
  endfunction

  function automatic row_t IDLE();
    return R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0,
             C_RUN, F_R, F_R);
  endfunction

  task automatic apply(input stim_t s);
    rs1_ad_d = s.rs1_d; rs2_ad_d = s.rs2_d;
    rs1_used_d = s.u1;  rs2_used_d = s.u2;
    rs1_ad_p = s.rs1_p; rs2_ad_p = s.rs2_p; rd_ad_p = s.rd_p;
    rdEn_p = s.en; rdmuxSel_p = s.mux;
    branch_taken_ex = s.br; dm_busy = s.busy;
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble};
    o.fa  = fwdA_sel;
    o.fb  = fwdB_sel;
    o.cnt = stall_cnt;
    return o;
  endfunction

  function automatic string show(input exp_t e);
    return $sformatf("ctl=%b fa=%b fb=%b cnt=%0d", e.ctl, e.fa, e.fb, e.cnt);
  endfunction

  function automatic exp_t mk_exp(input row_t r);
    exp_t e;
    e.ctl = r.ctl; e.fa = r.fa; e.fb = r.fb; e.cnt = exp_cnt;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t got, want;
    rst_n = 1'b0;
    apply(IDLE().s);
    dm_busy = 1'b1;          // reset must override the memory hold
    exp_cnt = 16'd0;
    #3;
    want = mk_exp(IDLE());
    exp_q.push_back(want);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL reset_early got %s want %s", show(got), show(want));
    else n_pass++;
    @(posedge clk); #1;
    exp_q.push_back(mk_exp(IDLE()));
    @(negedge clk);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL reset_held got %s want %s", show(got), show(want));
    else n_pass++;
    rst_n = 1'b1;
    apply(IDLE().s);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu_fwd();
    row_t t[10];
    exp_t got, want;
    t[0] = IDLE();
    t[1] = IDLE();
    t[2] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[3] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd4, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, F_E, F_R);
    t[4] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, F_M, F_R);
    t[5] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[6] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, C_RUN, F_R, F_E);
    t[7] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, F_E, F_E);
    t[8] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, F_M, F_M);
    t[9] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, F_R, F_R);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      apply(t[i].s);
      exp_q.push_back(mk_exp(t[i]));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL alu_fwd[%0d] got %s want %s", i, show(got), show(want));
      else n_pass++;
      if (!want.ctl[4] || want.ctl[2]) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_x0_guard();
    row_t t[6];
    exp_t got, want;
    t[0] = IDLE();
    t[1] = IDLE();
    // x0 load in EX read by ID: no stall, no forwarding
    t[2] = R(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[3] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[4] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[5] = IDLE();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply(t[i].s);
      exp_q.push_back(mk_exp(t[i]));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL x0_guard[%0d] got %s want %s", i, show(got), show(want));
      else n_pass++;
      if (!want.ctl[4] || want.ctl[2]) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pipeline view: stall cycle puts a bubble in EX while the consumer waits in
  // ID; the consumer reaches EX one cycle later and takes the load from MEM/WB.
  task automatic test_load_use();
    row_t t[7];
    exp_t got, want;
    t[0] = IDLE();
    // load x7 in EX, ID reads x7 only through an unused port
    t[1] = R(5'd7, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[2] = IDLE();
    // non-load writer of x7 with a matching ID source: forwarding, no stall
    t[3] = R(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 2'b10, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[4] = R(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, C_LU,  F_R, F_R);
    t[5] = R(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_RUN, F_R, F_R);
    t[6] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_RUN, F_R, F_M);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      apply(t[i].s);
      exp_q.push_back(mk_exp(t[i]));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL load_use[%0d] got %s want %s", i, show(got), show(want));
      else n_pass++;
      if (!want.ctl[4] || want.ctl[2]) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch();
    row_t t[6];
    exp_t got, want;
    t[0] = IDLE();
    t[1] = IDLE();
    t[2] = R(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 1'b1, 1'b0, C_BR,  F_R, F_R);
    // same load-use pattern in REDIRECT is masked
    t[3] = R(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, C_RUN, F_R, F_R);
    // back in RUN it stalls again
    t[4] = R(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, C_LU,  F_R, F_R);
    t[5] = IDLE();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply(t[i].s);
      exp_q.push_back(mk_exp(t[i]));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL branch[%0d] got %s want %s", i, show(got), show(want));
      else n_pass++;
      if (!want.ctl[4] || want.ctl[2]) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mem_wait();
    row_t t[10];
    exp_t got, want;
    t[0] = IDLE();
    t[1] = IDLE();
    t[2] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, C_RUN,  F_R, F_R);
    t[3] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, C_HOLD, F_E, F_R);
    t[4] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b1, C_HOLD, F_E, F_R);
    t[5] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b1, C_HOLD, F_E, F_R);
    // shadow held: x9 still in EX/MEM, x3 never captured
    t[6] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd3, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,  F_E, F_R);
    // branch arriving under a memory wait is taken once memory frees up
    t[7] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, C_HOLD, F_M, F_R);
    t[8] = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, C_BR,   F_M, F_R);
    t[9] = IDLE();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      apply(t[i].s);
      exp_q.push_back(mk_exp(t[i]));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL mem_wait[%0d] got %s want %s", i, show(got), show(want));
      else n_pass++;
      if (!want.ctl[4] || want.ctl[2]) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_stall();
    row_t a, b;
    exp_t got, want;
    a = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, C_RUN,  F_R, F_R);
    b = R(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, C_HOLD, F_E, F_R);
    @(posedge clk); #1;
    apply(a.s);
    exp_q.push_back(mk_exp(a));
    @(negedge clk);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL rst_mid_pre got %s want %s", show(got), show(want));
    else n_pass++;
    @(posedge clk); #1;
    apply(b.s);
    exp_q.push_back(mk_exp(b));
    @(negedge clk);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL rst_mid_wait got %s want %s", show(got), show(want));
    else n_pass++;
    // assert reset while dm_busy is still high
    #2;
    rst_n = 1'b0;
    exp_cnt = 16'd0;
    #1;
    exp_q.push_back(mk_exp(IDLE()));
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL rst_mid_now got %s want %s", show(got), show(want));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    apply(IDLE().s);
    @(posedge clk); #1;
    exp_q.push_back(mk_exp(IDLE()));
    @(negedge clk);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL rst_mid_after got %s want %s", show(got), show(want));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_x0_guard();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
